// File: rtl/key_event_fifo.sv
// Key event FIFO: synchronises the scanner interrupt, decodes each press into a 4-bit key index
// and queues it for the host. Optional auto-repeat is enabled by defining KEY_REPEAT_EN.
module key_event_fifo #(
  parameter int DEPTH_LOG2 = 3
`ifdef KEY_REPEAT_EN
  , parameter int TICK_DIV        = 1000,
  parameter int REPEAT_DELAY_MS = 500,
  parameter int REPEAT_RATE_MS  = 100
`endif
) (
  input  logic                  clk_1mhz,
  input  logic                  reset,
  input  logic                  key_irq_n,
  input  logic [7:0]            key_code_in,
  input  logic                  rd_en,
  input  logic                  ovf_clr,
  output logic [7:0]            dout,
  output logic                  empty,
  output logic                  full,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  overflow,
  output logic                  ghost_err,
  output logic                  irq_fifo_n
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] DEPTH_CNT = (DEPTH_LOG2 + 1)'(DEPTH);

  logic irq_s1, irq_s2, irq_prev;
  logic event_hit;
  logic [2:0] row_d, col_d;
  logic code_valid, real_push, ghost_set;
  logic [3:0] key_index;
  logic push_req, do_push, do_pop, ovf_set;
  logic [7:0] push_data;
  logic [7:0] mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr, rd_next;
  logic [DEPTH_LOG2:0] count_next;

  // Synchroniser flops idle high so reset never looks like a key press.
  always_ff @(posedge clk_1mhz or posedge reset) begin
    if (reset) begin
      irq_s1   <= 1'b1;
      irq_s2   <= 1'b1;
      irq_prev <= 1'b1;
    end else begin
      irq_s1   <= key_irq_n;
      irq_s2   <= irq_s1;
      irq_prev <= irq_s2;
    end
  end

  assign event_hit = irq_prev & ~irq_s2;

  // {valid, position} of the single low bit in an active-low nibble.
  function automatic logic [2:0] nib_pos(input logic [3:0] n);
    case (n)
      4'b1110: nib_pos = 3'b100;
      4'b1101: nib_pos = 3'b101;
      4'b1011: nib_pos = 3'b110;
      4'b0111: nib_pos = 3'b111;
      default: nib_pos = 3'b000;
    endcase
  endfunction

  assign row_d      = nib_pos(key_code_in[7:4]);
  assign col_d      = nib_pos(key_code_in[3:0]);
  assign code_valid = row_d[2] & col_d[2];
  assign key_index  = {row_d[1:0], col_d[1:0]};
  assign real_push  = event_hit & code_valid;
  assign ghost_set  = event_hit & ~code_valid;

`ifdef KEY_REPEAT_EN
  logic [31:0] tick_cnt, ms_cnt, ms_next;
  logic [7:0]  last_code;
  logic [3:0]  last_index;
  logic        rep_active, rep_first_done, tick, hold_ok, rep_fire;

  assign ms_next  = ms_cnt + 32'd1;
  assign tick     = (tick_cnt == 32'(TICK_DIV - 1));
  assign hold_ok  = (key_code_in == last_code) && (key_code_in != 8'hFF);
  assign rep_fire = rep_active & hold_ok & tick & ~event_hit &
                    (rep_first_done ? (ms_next == 32'(REPEAT_RATE_MS))
                                    : (ms_next == 32'(REPEAT_DELAY_MS)));
  assign push_req  = real_push | rep_fire;
  assign push_data = real_push ? {4'b0000, key_index} : {1'b1, 3'b000, last_index};

  // Any press restarts timing; only a press that was actually queued arms the repeat.
  always_ff @(posedge clk_1mhz or posedge reset) begin
    if (reset) begin
      tick_cnt       <= '0;
      ms_cnt         <= '0;
      last_code      <= 8'hFF;
      last_index     <= '0;
      rep_active     <= 1'b0;
      rep_first_done <= 1'b0;
    end else if (event_hit) begin
      tick_cnt       <= '0;
      ms_cnt         <= '0;
      rep_first_done <= 1'b0;
      rep_active     <= real_push & do_push;
      if (real_push & do_push) begin
        last_code  <= key_code_in;
        last_index <= key_index;
      end
    end else if (rep_active && !hold_ok) begin
      rep_active <= 1'b0;
    end else if (rep_active) begin
      tick_cnt <= tick ? '0 : tick_cnt + 32'd1;
      if (rep_fire) begin
        ms_cnt         <= '0;
        rep_first_done <= 1'b1;
      end else if (tick) begin
        ms_cnt <= ms_next;
      end
    end
  end
`else
  assign push_req  = real_push;
  assign push_data = {4'b0000, key_index};
`endif

  assign empty   = (count == '0);
  assign full    = (count == DEPTH_CNT);
  assign do_pop  = rd_en & ~empty;
  assign do_push = push_req & (~full | do_pop);
  assign ovf_set = push_req & ~do_push;
  assign rd_next = rd_ptr + 1'b1;

  always_comb begin
    count_next = count;
    if (do_push && !do_pop)
      count_next = count + 1'b1;
    else if (!do_push && do_pop)
      count_next = count - 1'b1;
  end

  always_ff @(posedge clk_1mhz) begin
    if (do_push)
      mem[wr_ptr] <= push_data;
  end

  // dout is a registered copy of the head, so it can hold its last value once drained.
  always_ff @(posedge clk_1mhz or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      dout       <= 8'h00;
      irq_fifo_n <= 1'b1;
      overflow   <= 1'b0;
      ghost_err  <= 1'b0;
    end else begin
      count      <= count_next;
      irq_fifo_n <= (count_next == '0);
      if (do_push)
        wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)
        rd_ptr <= rd_next;
      if (do_pop) begin
        if (count != 1)
          dout <= mem[rd_next];
        else if (do_push)
          dout <= push_data;
      end else if (do_push && empty) begin
        dout <= push_data;
      end
      if (ovf_set)
        overflow <= 1'b1;
      else if (ovf_clr)
        overflow <= 1'b0;
      if (ghost_set)
        ghost_err <= 1'b1;
      else if (ovf_clr)
        ghost_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_key_event_fifo.sv
// Self-checking bench for key_event_fifo: randomized key events against a queue-based model.
`timescale 1ns/1ps
module tb_key_event_fifo;

  logic       clk_1mhz = 1'b0;
  logic       reset, key_irq_n, rd_en, ovf_clr;
  logic [7:0] key_code_in;
  logic [7:0] dout;
  logic       empty, full, overflow, ghost_err, irq_fifo_n;
  logic [3:0] count;

  int checks = 0;
  int failures = 0;

  logic [7:0] model_q[$];
  logic       m_ovf, m_ghost;
  logic [7:0] m_head;

`ifdef KEY_REPEAT_EN
  key_event_fifo #(.DEPTH_LOG2(3), .TICK_DIV(10)) dut (
`else
  key_event_fifo #(.DEPTH_LOG2(3)) dut (
`endif
    .clk_1mhz(clk_1mhz), .reset(reset), .key_irq_n(key_irq_n), .key_code_in(key_code_in),
    .rd_en(rd_en), .ovf_clr(ovf_clr), .dout(dout), .empty(empty), .full(full),
    .count(count), .overflow(overflow), .ghost_err(ghost_err), .irq_fifo_n(irq_fifo_n)
  );

  always #500 clk_1mhz = ~clk_1mhz;

  // Position of the only low bit in a nibble, or -1 when there is not exactly one.
  function automatic int zero_pos(input logic [3:0] n);
    int zeros = 0;
    int pos = -1;
    for (int i = 0; i < 4; i++)
      if (!n[i]) begin
        zeros++;
        pos = i;
      end
    return (zeros == 1) ? pos : -1;
  endfunction

  function automatic logic [7:0] rand_valid_code();
    logic [3:0] rn = 4'hF;
    logic [3:0] cn = 4'hF;
    rn[$urandom_range(0, 3)] = 1'b0;
    cn[$urandom_range(0, 3)] = 1'b0;
    return {rn, cn};
  endfunction

  task automatic model_event(input logic [7:0] code, input logic rd, input logic clr);
    int r = zero_pos(code[7:4]);
    int c = zero_pos(code[3:0]);
    if (clr) begin
      m_ovf = 1'b0;
      m_ghost = 1'b0;
    end
    if (rd && model_q.size() > 0) void'(model_q.pop_front());
    if (r < 0 || c < 0) m_ghost = 1'b1;
    else if (model_q.size() < 8) model_q.push_back(8'(r * 4 + c));
    else m_ovf = 1'b1;
    if (model_q.size() > 0) m_head = model_q[0];
  endtask

  task automatic model_clear();
    model_q.delete();
    m_ovf = 1'b0;
    m_ghost = 1'b0;
    m_head = 8'h00;
  endtask

  // Full scanner interrupt pulse; rd_en/ovf_clr are applied in the cycle the event lands.
  task automatic press(input logic [7:0] code, input logic rd, input logic clr);
    @(negedge clk_1mhz);
    key_code_in = code;
    key_irq_n = 1'b0;
    @(posedge clk_1mhz);
    @(posedge clk_1mhz);
    @(negedge clk_1mhz);
    rd_en = rd;
    ovf_clr = clr;
    @(posedge clk_1mhz);
    model_event(code, rd, clr);
    @(negedge clk_1mhz);
    rd_en = 1'b0;
    ovf_clr = 1'b0;
    key_irq_n = 1'b1;
    repeat (3) @(negedge clk_1mhz);
    key_code_in = 8'hFF;
  endtask

  task automatic pop();
    @(negedge clk_1mhz);
    rd_en = 1'b1;
    @(posedge clk_1mhz);
    if (model_q.size() > 0) void'(model_q.pop_front());
    if (model_q.size() > 0) m_head = model_q[0];
    @(negedge clk_1mhz);
    rd_en = 1'b0;
  endtask

  task automatic clear_flags();
    @(negedge clk_1mhz);
    ovf_clr = 1'b1;
    @(posedge clk_1mhz);
    m_ovf = 1'b0;
    m_ghost = 1'b0;
    @(negedge clk_1mhz);
    ovf_clr = 1'b0;
  endtask

  task automatic drain();
    while (model_q.size() > 0) pop();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    key_irq_n = 1'b1;
    key_code_in = 8'hFF;
    rd_en = 1'b0;
    ovf_clr = 1'b0;
    model_clear();
    repeat (3) @(negedge clk_1mhz);
    reset = 1'b0;
    @(negedge clk_1mhz);
    checks++; if (count !== 4'd0) begin failures++; $display("[TB] FAIL reset_count got %0d want 0", count); end
    checks++; if (empty !== 1'b1) begin failures++; $display("[TB] FAIL reset_empty got %b want 1", empty); end
    checks++; if (full !== 1'b0) begin failures++; $display("[TB] FAIL reset_full got %b want 0", full); end
    checks++; if (dout !== 8'h00) begin failures++; $display("[TB] FAIL reset_dout got %h want 00", dout); end
    checks++; if (irq_fifo_n !== 1'b1) begin failures++; $display("[TB] FAIL reset_irq got %b want 1", irq_fifo_n); end
    checks++; if (overflow !== 1'b0 || ghost_err !== 1'b0) begin failures++; $display("[TB] FAIL reset_flags got %b%b want 00", overflow, ghost_err); end
  endtask

  task automatic test_single();
    logic [7:0] code = rand_valid_code();
    logic [7:0] want = 8'(zero_pos(code[7:4]) * 4 + zero_pos(code[3:0]));
    @(negedge clk_1mhz);
    key_code_in = code;
    key_irq_n = 1'b0;
    @(posedge clk_1mhz);
    @(posedge clk_1mhz);
    @(negedge clk_1mhz);
    checks++; if (count !== 4'd0) begin failures++; $display("[TB] FAIL latency_early got %0d want 0", count); end
    @(posedge clk_1mhz);
    model_event(code, 1'b0, 1'b0);
    @(negedge clk_1mhz);
    checks++; if (count !== 4'd1) begin failures++; $display("[TB] FAIL single_count got %0d want 1", count); end
    checks++; if (dout !== want) begin failures++; $display("[TB] FAIL single_dout code %h got %h want %h", code, dout, want); end
    checks++; if (irq_fifo_n !== 1'b0) begin failures++; $display("[TB] FAIL single_irq got %b want 0", irq_fifo_n); end
    key_irq_n = 1'b1;
    repeat (3) @(negedge clk_1mhz);
    key_code_in = 8'hFF;
    pop();
    checks++; if (empty !== 1'b1 || irq_fifo_n !== 1'b1) begin failures++; $display("[TB] FAIL single_pop got empty=%b irq=%b want 1 1", empty, irq_fifo_n); end
    checks++; if (dout !== want) begin failures++; $display("[TB] FAIL single_hold got %h want %h", dout, want); end
  endtask

  task automatic test_fill_overflow();
    logic [7:0] first;
    drain();
    for (int i = 0; i < 9; i++) press(rand_valid_code(), 1'b0, 1'b0);
    first = model_q[0];
    checks++; if (full !== 1'b1 || count !== 4'd8) begin failures++; $display("[TB] FAIL fill_full got full=%b count=%0d want 1 8", full, count); end
    checks++; if (overflow !== 1'b1) begin failures++; $display("[TB] FAIL fill_overflow got %b want 1", overflow); end
    checks++; if (dout !== first) begin failures++; $display("[TB] FAIL fill_head got %h want %h", dout, first); end
    clear_flags();
    checks++; if (overflow !== 1'b0) begin failures++; $display("[TB] FAIL ovf_clr got %b want 0", overflow); end
  endtask

  task automatic test_full_push_pop();
    press(rand_valid_code(), 1'b1, 1'b0);
    checks++; if (count !== 4'd8 || overflow !== 1'b0) begin failures++; $display("[TB] FAIL fullrw got count=%0d ovf=%b want 8 0", count, overflow); end
    checks++; if (dout !== model_q[0]) begin failures++; $display("[TB] FAIL fullrw_head got %h want %h", dout, model_q[0]); end
    for (int i = 0; i < 8; i++) begin
      checks++; if (dout !== model_q[0]) begin failures++; $display("[TB] FAIL drain_%0d got %h want %h", i, dout, model_q[0]); end
      pop();
    end
    checks++; if (empty !== 1'b1 || count !== 4'd0) begin failures++; $display("[TB] FAIL drain_empty got empty=%b count=%0d want 1 0", empty, count); end
  endtask

  task automatic test_empty_push_pop();
    press(rand_valid_code(), 1'b1, 1'b0);
    checks++; if (count !== 4'd1) begin failures++; $display("[TB] FAIL emptyrw_count got %0d want 1", count); end
    checks++; if (dout !== model_q[0]) begin failures++; $display("[TB] FAIL emptyrw_dout got %h want %h", dout, model_q[0]); end
    pop();
    pop();
    checks++; if (count !== 4'd0 || empty !== 1'b1) begin failures++; $display("[TB] FAIL underflow got count=%0d empty=%b want 0 1", count, empty); end
  endtask

  task automatic test_ghost();
    press(8'hCE, 1'b0, 1'b0);
    checks++; if (ghost_err !== 1'b1) begin failures++; $display("[TB] FAIL ghost_set got %b want 1", ghost_err); end
    checks++; if (count !== 4'(model_q.size())) begin failures++; $display("[TB] FAIL ghost_count got %0d want %0d", count, model_q.size()); end
    press(8'hFF, 1'b0, 1'b1);
    checks++; if (ghost_err !== 1'b1) begin failures++; $display("[TB] FAIL ghost_set_wins got %b want 1", ghost_err); end
    clear_flags();
    checks++; if (ghost_err !== 1'b0) begin failures++; $display("[TB] FAIL ghost_clr got %b want 0", ghost_err); end
  endtask

  task automatic test_random();
    for (int it = 0; it < 60; it++) begin
      int op = $urandom_range(0, 9);
      if (op < 6) begin
        logic [7:0] code = ($urandom_range(0, 9) == 0) ? 8'($urandom) : rand_valid_code();
        press(code, 1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 4) == 0));
      end else if (op < 9) pop();
      else clear_flags();
      checks++; if (count !== 4'(model_q.size())) begin failures++; $display("[TB] FAIL rnd_count it=%0d got %0d want %0d", it, count, model_q.size()); end
      checks++; if (dout !== m_head) begin failures++; $display("[TB] FAIL rnd_dout it=%0d got %h want %h", it, dout, m_head); end
      checks++; if (overflow !== m_ovf || ghost_err !== m_ghost) begin failures++; $display("[TB] FAIL rnd_flags it=%0d got %b%b want %b%b", it, overflow, ghost_err, m_ovf, m_ghost); end
      checks++; if (irq_fifo_n !== (model_q.size() == 0) || full !== (model_q.size() == 8)) begin failures++; $display("[TB] FAIL rnd_status it=%0d got irq=%b full=%b", it, irq_fifo_n, full); end
    end
  endtask

  task automatic test_mid_reset();
    drain();
    for (int i = 0; i < 3; i++) press(rand_valid_code(), 1'b0, 1'b0);
    @(posedge clk_1mhz);
    #250 reset = 1'b1;
    @(negedge clk_1mhz);
    checks++; if (count !== 4'd0 || empty !== 1'b1) begin failures++; $display("[TB] FAIL midreset_count got %0d empty=%b want 0 1", count, empty); end
    checks++; if (irq_fifo_n !== 1'b1 || dout !== 8'h00) begin failures++; $display("[TB] FAIL midreset_out got irq=%b dout=%h want 1 00", irq_fifo_n, dout); end
    reset = 1'b0;
    model_clear();
    @(negedge clk_1mhz);
  endtask

`ifdef KEY_REPEAT_EN
  task automatic test_repeat();
    logic [7:0] want [4] = '{8'h09, 8'h89, 8'h89, 8'h89};
    drain();
    @(negedge clk_1mhz);
    key_code_in = 8'hBD;
    key_irq_n = 1'b0;
    repeat (5) @(negedge clk_1mhz);
    key_irq_n = 1'b1;
    repeat (750 * 10) @(negedge clk_1mhz);
    checks++; if (count !== 4'd4) begin failures++; $display("[TB] FAIL repeat_count got %0d want 4", count); end
    key_code_in = 8'hFF;
    repeat (300 * 10) @(negedge clk_1mhz);
    checks++; if (count !== 4'd4) begin failures++; $display("[TB] FAIL repeat_stop got %0d want 4", count); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (dout !== want[i]) begin failures++; $display("[TB] FAIL repeat_entry_%0d got %h want %h", i, dout, want[i]); end
      @(negedge clk_1mhz); rd_en = 1'b1;
      @(negedge clk_1mhz); rd_en = 1'b0;
    end
    m_head = 8'h89;
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_fill_overflow();
    test_full_push_pop();
    test_empty_push_pop();
    test_ghost();
    test_random();
    test_mid_reset();
`ifdef KEY_REPEAT_EN
    test_repeat();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #80_000_000;
    failures++;
    $display("[TB] FAIL watchdog timeout");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "[TB] timeout");
  end

endmodule
